// File: rtl/sub_result_capture.sv
// sub_result_capture
//   Downstream capture stage of the 64-bit subtractor. On each accepted
//   (in_a, in_b, in_result) triple, the difference and its unsigned borrow
//   are pushed into a 2-entry skid FIFO. The FIFO head is presented
//   downstream with its own valid/ready handshake. The stage also keeps a
//   running modular sum and a saturating count of accepted differences.
//
//   Optional build macro SUB_RESULT_CHECK_EN adds a self-check: on each
//   accept, in_result is compared with in_a - in_b. A mismatch sets the
//   sticky output check_err, which only rst clears.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   in_valid / in_ready       upstream handshake (in_ready is registered)
//   in_a, in_b, in_result     operands and subtractor difference
//   clear                     synchronous clear of acc_sum / acc_count
//   out_valid / out_ready     downstream handshake
//   out_result, out_borrow    head entry difference and borrow flag
//   acc_sum                   sum of accepted in_result, mod 2^WIDTH
//   acc_count                 accepted transactions, saturating
//   check_err                 (SUB_RESULT_CHECK_EN only) sticky mismatch flag
module sub_result_capture #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_result,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_borrow,
  output logic [WIDTH-1:0] acc_sum,
  output logic [CNT_W-1:0] acc_count
`ifdef SUB_RESULT_CHECK_EN
  ,
  output logic             check_err
`endif
);

  logic [1:0]       r_count;
  logic             r_head;
  logic             r_tail;
  logic [WIDTH-1:0] r_res [2];
  logic             r_brw [2];
  logic             r_in_ready;
  logic [WIDTH-1:0] r_acc_sum;
  logic [CNT_W-1:0] r_acc_count;

  logic             w_accept;
  logic             w_pop;
  logic [1:0]       w_count_nxt;

  assign w_accept = in_valid && r_in_ready;
  assign w_pop    = (r_count != 2'd0) && out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // in_ready is registered from the next occupancy, so it holds 0 through
  // reset, rises on the first edge after release, and never depends on
  // out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_in_ready <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_res[i] <= '0;
        r_brw[i] <= 1'b0;
      end
    end else begin
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
      if (w_accept) begin
        r_res[r_tail] <= in_result;
        r_brw[r_tail] <= (in_a < in_b);
        r_tail        <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_sum   <= '0;
      r_acc_count <= '0;
    end else if (clear) begin
      // A coincident accept counts as the first transaction after clearing.
      if (w_accept) begin
        r_acc_sum   <= in_result;
        r_acc_count <= CNT_W'(1);
      end else begin
        r_acc_sum   <= '0;
        r_acc_count <= '0;
      end
    end else if (w_accept) begin
      r_acc_sum <= r_acc_sum + in_result;
      if (r_acc_count != '1) begin
        r_acc_count <= r_acc_count + CNT_W'(1);
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_count != 2'd0);
  assign out_result = r_res[r_head];
  assign out_borrow = r_brw[r_head];
  assign acc_sum    = r_acc_sum;
  assign acc_count  = r_acc_count;

`ifdef SUB_RESULT_CHECK_EN
  logic [WIDTH-1:0] w_expect;
  logic             w_mismatch;
  logic             r_check_err;

  assign w_expect   = in_a - in_b;
  assign w_mismatch = w_accept && (in_result != w_expect);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_check_err <= 1'b0;
    end else if (w_mismatch) begin
      r_check_err <= 1'b1;
    end
  end

  assign check_err = r_check_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_mismatch) begin
      $error("sub_result_capture: a=%h b=%h expected=%h got=%h",
             in_a, in_b, w_expect, in_result);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_sub_result_capture.sv
module tb_sub_result_capture;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_result;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_borrow;
  logic [WIDTH-1:0] acc_sum;
  logic [CNT_W-1:0] acc_count;
`ifdef SUB_RESULT_CHECK_EN
  logic             check_err;
`endif

  int checks;
  int errors;

  sub_result_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_result  (in_result),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_borrow (out_borrow),
    .acc_sum    (acc_sum),
    .acc_count  (acc_count)
`ifdef SUB_RESULT_CHECK_EN
    ,
    .check_err  (check_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] r);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_result = r;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 64'd0 || out_borrow !== 1'b0) begin errors++; $display("FAIL reset_out_data got=%h/%b exp=0/0", out_result, out_borrow); end
    checks++; if (acc_sum !== 64'd0 || acc_count !== 32'd0) begin errors++; $display("FAIL reset_acc got=%0d/%0d exp=0/0", acc_sum, acc_count); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 64'd10, 64'd3, 64'd7);
    tick();
    drive(1'b0, '0, '0, '0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 64'd7 || out_borrow !== 1'b0) begin errors++; $display("FAIL single_data got=%0d/%b exp=7/0", out_result, out_borrow); end
    checks++; if (acc_sum !== 64'd7 || acc_count !== 32'd1) begin errors++; $display("FAIL single_acc got=%0d/%0d exp=7/1", acc_sum, acc_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_borrow_wrap();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (acc_sum !== 64'd0 || acc_count !== 32'd0) begin errors++; $display("FAIL clear_only got=%0d/%0d exp=0/0", acc_sum, acc_count); end
    out_ready = 1'b1;
    drive(1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checks++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFF || out_borrow !== 1'b1) begin errors++; $display("FAIL borrow_data got=%h/%b exp=ffffffffffffffff/1", out_result, out_borrow); end
    drive(1'b1, 64'd5, 64'd3, 64'd2);
    tick();
    drive(1'b0, '0, '0, '0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd2 || out_borrow !== 1'b0) begin errors++; $display("FAIL accept_pop_data got=%b/%0d/%b exp=1/2/0", out_valid, out_result, out_borrow); end
    checks++; if (acc_sum !== 64'd1 || acc_count !== 32'd2) begin errors++; $display("FAIL wrap_acc got=%0d/%0d exp=1/2", acc_sum, acc_count); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(1'b1, 64'd1, 64'd0, 64'd1);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    drive(1'b1, 64'd2, 64'd0, 64'd2);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got=%b exp=0", in_ready); end
    drive(1'b1, 64'd3, 64'd0, 64'd3);
    tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 64'd1) begin errors++; $display("FAIL bp_stall1 got=%b/%b/%0d exp=0/1/1", in_ready, out_valid, out_result); end
    tick();
    checks++; if (out_result !== 64'd1 || acc_count !== 32'd4) begin errors++; $display("FAIL bp_stall2 got=%0d/%0d exp=1/4", out_result, acc_count); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_result !== 64'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1 got=%0d/%b exp=2/1", out_result, in_ready); end
    tick();
    drive(1'b0, '0, '0, '0);
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd3) begin errors++; $display("FAIL bp_pop2 got=%b/%0d exp=1/3", out_valid, out_result); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    checks++; if (acc_sum !== 64'd7 || acc_count !== 32'd5) begin errors++; $display("FAIL bp_acc got=%0d/%0d exp=7/5", acc_sum, acc_count); end
  endtask

  task automatic test_clear();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 64'd10; vals[1] = 64'd20; vals[2] = 64'd30; vals[3] = 64'd40;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i], 64'd0, vals[i]);
      tick();
    end
    checks++; if (acc_sum !== 64'd100 || acc_count !== 32'd4) begin errors++; $display("FAIL pre_clear_acc got=%0d/%0d exp=100/4", acc_sum, acc_count); end
    drive(1'b1, 64'd9, 64'd0, 64'd9);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    checks++; if (acc_sum !== 64'd9 || acc_count !== 32'd1) begin errors++; $display("FAIL clear_accept_acc got=%0d/%0d exp=9/1", acc_sum, acc_count); end
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd9) begin errors++; $display("FAIL clear_accept_buf got=%b/%0d exp=1/9", out_valid, out_result); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd9 || in_ready !== 1'b1) begin errors++; $display("FAIL clear_buf_kept got=%b/%0d/%b exp=1/9/1", out_valid, out_result, in_ready); end
    checks++; if (acc_sum !== 64'd0 || acc_count !== 32'd0) begin errors++; $display("FAIL clear_idle_acc got=%0d/%0d exp=0/0", acc_sum, acc_count); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 64'd4, 64'd0, 64'd4);
    tick();
    drive(1'b0, '0, '0, '0);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_async got=%b/%b exp=0/0", out_valid, in_ready); end
    checks++; if (acc_count !== 32'd0 || out_result !== 64'd0) begin errors++; $display("FAIL mid_async_state got=%0d/%0d exp=0/0", acc_count, out_result); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_recover got=%b/%b exp=0/1", out_valid, in_ready); end
  endtask

`ifdef SUB_RESULT_CHECK_EN
  task automatic test_check();
    out_ready = 1'b1;
    checks++; if (check_err !== 1'b0) begin errors++; $display("FAIL chk_initial got=%b exp=0", check_err); end
    drive(1'b1, 64'd8, 64'd2, 64'd5);
    tick();
    checks++; if (check_err !== 1'b1) begin errors++; $display("FAIL chk_set got=%b exp=1", check_err); end
    drive(1'b1, 64'd8, 64'd2, 64'd6);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b0, '0, '0, '0);
    tick();
    checks++; if (check_err !== 1'b1) begin errors++; $display("FAIL chk_sticky got=%b exp=1", check_err); end
    rst = 1'b1;
    #1;
    checks++; if (check_err !== 1'b0) begin errors++; $display("FAIL chk_rst got=%b exp=0", check_err); end
    tick();
    rst = 1'b0;
    tick();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    fork
      begin
        test_reset();
        test_single();
        test_borrow_wrap();
        test_back_to_back();
        test_clear();
        test_reset_mid();
`ifdef SUB_RESULT_CHECK_EN
        test_check();
`endif
      end
      begin
        #100000;
        errors++;
        $display("FAIL timeout got=running exp=done");
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
